// File: rtl/alu_seq_pkg.sv
// Shared types and default sizes for the ALU sequencer and its program memory.
package alu_seq_pkg;

  localparam int unsigned OPW_DEF   = 4;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW_DEF-1:0] op;
    logic               src;
    logic               last;
  } prog_word_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: synchronous write, asynchronous read, cleared by reset.
module seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  prog_word_t    wdata,
  input  logic [AW-1:0] raddr,
  output prog_word_t    rdata
);

  prog_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the operand/ALU/result datapath through a small stored program of ALU ops.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW   = OPW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_addr,
  input  logic [OPW-1:0] prog_op,
  input  logic           prog_src,
  input  logic           prog_last,
  output logic           reg0_en,
  output logic           reg1_en,
  output logic [OPW-1:0] alu_op,
  output logic           src_sel,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  pc
);

  state_t        state;
  logic [AW-1:0] pc_q;
  logic          start_q;
  logic          start_edge;
  logic          mem_we;
  prog_word_t    wdata;
  prog_word_t    word;

  assign start_edge = start & ~start_q;
  assign mem_we     = prog_we & (state == IDLE);
  assign wdata      = '{op: OPW_DEF'(prog_op), src: prog_src, last: prog_last};

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (wdata),
    .raddr (pc_q),
    .rdata (word)
  );

  // start_q resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      start_q <= 1'b1;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          pc_q <= '0;
          if (start_edge && !abort) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            pc_q  <= '0;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (abort) begin
            state <= IDLE;
            pc_q  <= '0;
          end else if (word.last || (pc_q == AW'(DEPTH - 1))) begin
            state <= DONE;
          end else begin
            pc_q <= pc_q + AW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          pc_q  <= '0;
        end
        default: begin
          state <= IDLE;
          pc_q  <= '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from the registered state and program word.
  always_comb begin
    reg0_en = 1'b0;
    reg1_en = 1'b0;
    alu_op  = '0;
    src_sel = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      LOAD: begin
        reg0_en = 1'b1;
        busy    = 1'b1;
      end
      EXEC: begin
        reg1_en = 1'b1;
        busy    = 1'b1;
        alu_op  = OPW'(word.op);
        src_sel = word.src;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc = pc_q;

endmodule
